retire_trace_buffer: RTL and testbench

// Downstream consumer of the hart retire interface. Each retired instruction is

---
 rtl/trace_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 60 ++++++
 rtl/retire_trace_buffer.sv | 113 +++++++++++
 tb/tb_retire_trace_buffer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared record layout for the retire trace buffer.
// The cycle field is sized for the widest supported stamp; the buffer keeps only its low CYC_W bits.
package trace_pkg;

    localparam int DROP_W    = 16;
    localparam int CYC_MAX_W = 64;

    typedef struct packed {
        logic [CYC_MAX_W-1:0] cycle;
        logic [31:0]          pc;
        logic [31:0]          next_pc;
        logic [31:0]          inst;
        logic [4:0]           rd_waddr;
        logic [31:0]          rd_wdata;
        logic                 trap;
        logic                 halt;
    } retire_rec_t;

    localparam int REC_W       = $bits(retire_rec_t);
    localparam int REC_FIXED_W = REC_W - CYC_MAX_W;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with separately tracked level; pointers wrap naturally.
// Storage is not reset, so read data is meaningless while empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int LVL_W  = ADDR_W + 1;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (i_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (i_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({i_push, i_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push) mem_q[wr_ptr_q] <= i_wdata;
    end

    assign o_rdata = mem_q[rd_ptr_q];
    assign o_level = level_q;
    assign o_full  = (level_q == LVL_W'(DEPTH));
    assign o_empty = (level_q == '0);

endmodule

// File: rtl/retire_trace_buffer.sv
// Captures each hart retire into a stamped record and drains records over a valid/ready port.
// Tracks overflow drops (saturating), sticky halt, and end-of-trace.
module retire_trace_buffer
    import trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CYC_W = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_retire_valid,
    input  logic [31:0]            i_retire_inst,
    input  logic                   i_retire_trap,
    input  logic                   i_retire_halt,
    input  logic [4:0]             i_retire_rd_waddr,
    input  logic [31:0]            i_retire_rd_wdata,
    input  logic [31:0]            i_retire_pc,
    input  logic [31:0]            i_retire_next_pc,
    output logic                   o_trace_valid,
    input  logic                   i_trace_ready,
    output logic [CYC_W-1:0]       o_trace_cycle,
    output logic [31:0]            o_trace_pc,
    output logic [31:0]            o_trace_next_pc,
    output logic [31:0]            o_trace_inst,
    output logic [31:0]            o_trace_rd_wdata,
    output logic [4:0]             o_trace_rd_waddr,
    output logic                   o_trace_trap,
    output logic                   o_trace_halt,
    output logic [$clog2(DEPTH):0] o_level,
    output logic [15:0]            o_drop_count,
    output logic                   o_halted,
    output logic                   o_drained
);

    localparam int FIFO_W = REC_FIXED_W + CYC_W;

    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [DROP_W-1:0] drop_count_q, drop_count_d;
    logic              halted_q, halted_d;

    logic              retire_ok, push, pop, drop;
    logic              fifo_full, fifo_empty;
    logic [FIFO_W-1:0] fifo_wdata, fifo_rdata;
    retire_rec_t       wr_rec, rd_rec;

    // Once halted the hart is considered stopped: later retires neither queue nor count as drops.
    always_comb begin
        retire_ok    = i_retire_valid && !halted_q;
        pop          = !fifo_empty && i_trace_ready;
        push         = retire_ok && (!fifo_full || pop);
        drop         = retire_ok && fifo_full && !pop;
        cyc_d        = cyc_q + 1'b1;
        halted_d     = halted_q || (retire_ok && i_retire_halt);
        drop_count_d = drop_count_q;
        if (drop && (drop_count_q != '1)) drop_count_d = drop_count_q + 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cyc_q        <= '0;
            drop_count_q <= '0;
            halted_q     <= 1'b0;
        end else begin
            cyc_q        <= cyc_d;
            drop_count_q <= drop_count_d;
            halted_q     <= halted_d;
        end
    end

    // The stamp is the MSB field, so truncating the packed record drops only unused cycle bits.
    always_comb begin
        wr_rec          = '0;
        wr_rec.cycle    = CYC_MAX_W'(cyc_q);
        wr_rec.pc       = i_retire_pc;
        wr_rec.next_pc  = i_retire_next_pc;
        wr_rec.inst     = i_retire_inst;
        wr_rec.rd_waddr = i_retire_rd_waddr;
        wr_rec.rd_wdata = i_retire_rd_wdata;
        wr_rec.trap     = i_retire_trap;
        wr_rec.halt     = i_retire_halt;
        fifo_wdata      = wr_rec[FIFO_W-1:0];
        rd_rec          = retire_rec_t'(REC_W'(fifo_rdata));
    end

    sync_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (push),
        .i_pop   (pop),
        .i_wdata (fifo_wdata),
        .o_rdata (fifo_rdata),
        .o_level (o_level),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    assign o_trace_valid    = !fifo_empty;
    assign o_trace_cycle    = rd_rec.cycle[CYC_W-1:0];
    assign o_trace_pc       = rd_rec.pc;
    assign o_trace_next_pc  = rd_rec.next_pc;
    assign o_trace_inst     = rd_rec.inst;
    assign o_trace_rd_wdata = rd_rec.rd_wdata;
    assign o_trace_rd_waddr = rd_rec.rd_waddr;
    assign o_trace_trap     = rd_rec.trap;
    assign o_trace_halt     = rd_rec.halt;
    assign o_drop_count     = drop_count_q;
    assign o_halted         = halted_q;
    assign o_drained        = halted_q && fifo_empty;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Randomized and directed bench for retire_trace_buffer against a queue-based reference model.
module tb_retire_trace_buffer;

    localparam int DEPTH = 16;
    localparam int CYC_W = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        r_valid = 1'b0, r_trap = 1'b0, r_halt = 1'b0, t_ready = 1'b0;
    logic [31:0] r_inst = '0, r_wdata = '0, r_pc = '0, r_npc = '0;
    logic [4:0]  r_rd = '0;

    logic             t_valid, t_trap, t_halt, halted, drained;
    logic [CYC_W-1:0] t_cycle;
    logic [31:0]      t_pc, t_npc, t_inst, t_wdata;
    logic [4:0]       t_rd;
    logic [$clog2(DEPTH):0] level;
    logic [15:0]      drop_count;

    retire_trace_buffer #(.DEPTH(DEPTH), .CYC_W(CYC_W)) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_retire_valid    (r_valid),
        .i_retire_inst     (r_inst),
        .i_retire_trap     (r_trap),
        .i_retire_halt     (r_halt),
        .i_retire_rd_waddr (r_rd),
        .i_retire_rd_wdata (r_wdata),
        .i_retire_pc       (r_pc),
        .i_retire_next_pc  (r_npc),
        .o_trace_valid     (t_valid),
        .i_trace_ready     (t_ready),
        .o_trace_cycle     (t_cycle),
        .o_trace_pc        (t_pc),
        .o_trace_next_pc   (t_npc),
        .o_trace_inst      (t_inst),
        .o_trace_rd_wdata  (t_wdata),
        .o_trace_rd_waddr  (t_rd),
        .o_trace_trap      (t_trap),
        .o_trace_halt      (t_halt),
        .o_level           (level),
        .o_drop_count      (drop_count),
        .o_halted          (halted),
        .o_drained         (drained)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] cyc, pc, npc, inst, wdata;
        logic [4:0]  rd;
        logic        trap, halt;
    } mrec_t;

    mrec_t       mq[$];
    int unsigned m_cyc;
    int unsigned m_drop;
    bit          m_halted;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_cyc    = 0;
        m_drop   = 0;
        m_halted = 0;
    endtask

    // Applies one clock edge of behaviour to the model using the currently driven inputs.
    task automatic model_edge();
        bit    do_pop, ok, do_push;
        mrec_t r;
        do_pop  = (mq.size() > 0) && t_ready;
        ok      = r_valid && !m_halted;
        do_push = ok && ((mq.size() < DEPTH) || do_pop);
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
            r.cyc = m_cyc; r.pc = r_pc; r.npc = r_npc; r.inst = r_inst;
            r.wdata = r_wdata; r.rd = r_rd; r.trap = r_trap; r.halt = r_halt;
            mq.push_back(r);
        end
        if (ok && !do_push && m_drop < 16'hFFFF) m_drop++;
        if (ok && r_halt) m_halted = 1;
        m_cyc++;
    endtask

    task automatic check_outputs();
        chk("valid", t_valid, mq.size() > 0);
        chk("level", level, mq.size());
        chk("drops", drop_count, m_drop);
        chk("halted", halted, m_halted);
        chk("drained", drained, m_halted && mq.size() == 0);
        if (mq.size() > 0) begin
            chk("cycle", t_cycle, mq[0].cyc);
            chk("pc", t_pc, mq[0].pc);
            chk("next_pc", t_npc, mq[0].npc);
            chk("inst", t_inst, mq[0].inst);
            chk("rd", t_rd, mq[0].rd);
            chk("rd_wdata", t_wdata, mq[0].wdata);
            chk("trap", t_trap, mq[0].trap);
            chk("halt", t_halt, mq[0].halt);
        end
    endtask

    // Drive one cycle of inputs (called at negedge), clock it, and check at the next negedge.
    task automatic drive(input bit v, input logic [31:0] pc, input bit h, input bit rdy);
        r_valid = v; r_pc = pc; r_npc = pc + 32'd4; r_halt = h; t_ready = rdy;
        r_inst  = $urandom; r_wdata = $urandom; r_rd = 5'($urandom);
        r_trap  = ($urandom_range(0, 7) == 0);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; r_valid = 1'b0; r_halt = 1'b0; t_ready = 1'b0;
        model_reset();
        @(negedge clk);
        check_outputs();
        chk("rst_valid", t_valid, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        do_reset();

        // In-order drain with ready held high; occupancy never above one.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'(i * 4), 1'b0, 1'b1);
            chk("lvl_le1", level <= 1, 1'b1);
        end
        for (int i = 0; i < 2; i++) drive(1'b0, '0, 1'b0, 1'b1);

        // Overflow with a stalled sink, then push+pop while full.
        do_reset();
        for (int i = 0; i < DEPTH + 2; i++) drive(1'b1, 32'h100 + 32'(i * 4), 1'b0, 1'b0);
        chk("full_level", level, DEPTH);
        chk("full_drops", drop_count, 2);
        drive(1'b1, 32'h200, 1'b0, 1'b1);
        chk("pushpop_level", level, DEPTH);
        chk("pushpop_drops", drop_count, 2);
        for (int i = 0; i < DEPTH + 1; i++) drive(1'b0, '0, 1'b0, 1'b1);
        chk("empty_after", t_valid, 1'b0);

        // Drop counter saturation.
        do_reset();
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 32'h300 + 32'(i * 4), 1'b0, 1'b0);
        force dut.drop_count_q = 16'hFFFD;
        #1;
        release dut.drop_count_q;
        m_drop = 16'hFFFD;
        for (int i = 0; i < 3; i++) drive(1'b1, 32'h400, 1'b0, 1'b0);
        chk("sat_drops", drop_count, 16'hFFFF);

        // Halt, ignored retires, drain to end-of-trace.
        do_reset();
        drive(1'b1, 32'h38, 1'b0, 1'b0);
        drive(1'b1, 32'h3C, 1'b0, 1'b0);
        drive(1'b1, 32'h40, 1'b1, 1'b0);
        drive(1'b1, 32'h44, 1'b0, 1'b0);
        drive(1'b1, 32'h48, 1'b0, 1'b0);
        chk("halt_sticky", halted, 1'b1);
        chk("halt_level", level, 3);
        chk("halt_drops", drop_count, 0);
        for (int i = 0; i < 3; i++) drive(1'b1, 32'h50, 1'b0, 1'b1);
        chk("halt_drained", drained, 1'b1);

        // Asynchronous reset mid-burst takes effect before the next edge.
        do_reset();
        for (int i = 0; i < 5; i++) drive(1'b1, 32'h500 + 32'(i * 4), 1'b0, 1'b0);
        chk("pre_rst_level", level, 5);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", t_valid, 1'b0);
        chk("arst_level", level, 0);
        chk("arst_drops", drop_count, 0);
        chk("arst_halted", halted, 1'b0);
        chk("arst_drained", drained, 1'b0);
        model_reset();
        @(negedge clk);
        r_valid = 1'b0;
        rst_n = 1'b1;

        // Random traffic with varying sink pressure.
        for (int round = 0; round < 4; round++) begin
            int rdy_pct;
            do_reset();
            rdy_pct = (round == 0) ? 90 : (round == 1) ? 50 : (round == 2) ? 20 : 70;
            for (int c = 0; c < 200; c++) begin
                drive($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 149) == 0,
                      $urandom_range(0, 99) < rdy_pct);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
